// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory access and
// writeback, and counts retired instructions (cycles that update the PC).
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instructionOp,
    input  logic [3:0]  flagOp,
    input  logic [4:0]  flags,
    input  logic        memReady,
    output logic        irLoad,
    output logic        pcEn,
    output logic [1:0]  pcSel,
    output logic        regWrite,
    output logic [1:0]  wbSel,
    output logic        flagWrite,
    output logic        memReq,
    output logic        memWrite,
    output logic        addrSel,
    output logic [2:0]  state,
    output logic [15:0] instrCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic [3:0] op_hi;
    logic       is_alu, is_load, is_stor, is_jal, is_jcond, is_bcond;
    logic       writes_flags, cond_true;
    logic       flag_z, flag_c, flag_f, flag_n, flag_l;

    assign op_hi        = instructionOp[7:4];
    assign is_alu       = (op_hi == 4'h0) || instructionOp[5] || instructionOp[4]
                          || (op_hi == 4'h8);
    assign is_load      = (instructionOp == 8'h40);
    assign is_stor      = (instructionOp == 8'h44);
    assign is_jal       = (instructionOp == 8'h48);
    assign is_jcond     = (op_hi == 4'h4) && (instructionOp[3:0] == 4'hC);
    assign is_bcond     = (op_hi == 4'hC);
    // MOV, MOVI and LUI only move data, so they leave the PSR untouched.
    assign writes_flags = !((instructionOp == 8'h0D) || (op_hi == 4'hD) || (op_hi == 4'hF));

    assign {flag_z, flag_c, flag_f, flag_n, flag_l} = flags;

    always_comb begin
        case (flagOp)
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_l;
            4'h5:    cond_true = !flag_l;
            4'h6:    cond_true = flag_n;
            4'h7:    cond_true = !flag_n;
            4'h8:    cond_true = flag_f;
            4'h9:    cond_true = !flag_f;
            4'hA:    cond_true = !flag_l && !flag_z;
            4'hB:    cond_true = flag_l || flag_z;
            4'hC:    cond_true = !flag_n && !flag_z;
            4'hD:    cond_true = flag_n || flag_z;
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // NOTE: every output and next-state value gets a default before the case so
    // no path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        irLoad        = 1'b0;
        pcEn          = 1'b0;
        pcSel         = 2'b00;
        regWrite      = 1'b0;
        wbSel         = 2'b00;
        flagWrite     = 1'b0;
        memReq        = 1'b0;
        memWrite      = 1'b0;
        addrSel       = 1'b0;
        state_d       = state_q;
        instr_count_d = instr_count_q;

        case (state_q)
            S_FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irLoad  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu) begin
                    regWrite  = 1'b1;
                    pcEn      = 1'b1;
                    flagWrite = writes_flags;
                end else if (is_load || is_stor) begin
                    state_d = S_MEM;
                end else if (is_jal) begin
                    regWrite = 1'b1;
                    wbSel    = 2'b10;
                    pcEn     = 1'b1;
                    pcSel    = 2'b10;
                end else if (is_jcond) begin
                    pcEn  = 1'b1;
                    pcSel = cond_true ? 2'b10 : 2'b00;
                end else if (is_bcond) begin
                    pcEn  = 1'b1;
                    pcSel = cond_true ? 2'b01 : 2'b00;
                end else begin
                    pcEn = 1'b1;
                end
            end
            S_MEM: begin
                memReq   = 1'b1;
                addrSel  = 1'b1;
                memWrite = is_stor;
                if (memReady) begin
                    if (is_stor) begin
                        pcEn    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                wbSel    = 2'b01;
                pcEn     = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            irLoad    = 1'b0;
            pcEn      = 1'b0;
            pcSel     = 2'b00;
            regWrite  = 1'b0;
            wbSel     = 2'b00;
            flagWrite = 1'b0;
            memReq    = 1'b0;
            memWrite  = 1'b0;
            addrSel   = 1'b0;
        end

        if (pcEn) begin
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state      = state_q;
    assign instrCount = instr_count_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller: each instruction is expanded into its
// expected per-cycle strobe pattern from the instruction's class and checked.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instructionOp = 8'h00;
    logic [3:0]  flagOp = 4'h0;
    logic [4:0]  flags = 5'h00;
    logic        memReady = 1'b0;
    logic        irLoad, pcEn, regWrite, flagWrite, memReq, memWrite, addrSel;
    logic [1:0]  pcSel, wbSel;
    logic [2:0]  state;
    logic [15:0] instrCount;

    cpu_controller dut (
        .clk           (clk),
        .reset         (reset),
        .instructionOp (instructionOp),
        .flagOp        (flagOp),
        .flags         (flags),
        .memReady      (memReady),
        .irLoad        (irLoad),
        .pcEn          (pcEn),
        .pcSel         (pcSel),
        .regWrite      (regWrite),
        .wbSel         (wbSel),
        .flagWrite     (flagWrite),
        .memReq        (memReq),
        .memWrite      (memWrite),
        .addrSel       (addrSel),
        .state         (state),
        .instrCount    (instrCount)
    );

    always #5 clk = ~clk;

    typedef enum {K_ALU, K_LOAD, K_STOR, K_JAL, K_JMP, K_BR, K_NOP} kind_e;

    typedef struct packed {
        logic       ir_load;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       flag_write;
        logic       mem_req;
        logic       mem_write;
        logic       addr_sel;
        logic [2:0] st;
    } obs_t;

    int n_checks = 0;
    int n_pass = 0;
    int model_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic kind_e classify(input logic [7:0] op);
        if (op[7:4] == 4'h0 || op[5] || op[4] || op[7:4] == 4'h8) return K_ALU;
        if (op == 8'h40) return K_LOAD;
        if (op == 8'h44) return K_STOR;
        if (op == 8'h48) return K_JAL;
        if (op == 8'h4C) return K_JMP;
        if (op[7:4] == 4'hC) return K_BR;
        return K_NOP;
    endfunction

    function automatic logic cond_true(input logic [3:0] fop, input logic [4:0] flg);
        logic z, c, f, n, l;
        {z, c, f, n, l} = flg;
        case (fop)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic obs_t fetch_wait();
        obs_t e;
        e = blank(3'd0);
        e.mem_req = 1'b1;
        return e;
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample just after.
    task automatic cycle(input string tag, input logic rst, input logic ready,
                         input logic [7:0] op, input logic [3:0] fop,
                         input logic [4:0] flg, input obs_t exp);
        obs_t got;
        @(negedge clk);
        reset = rst;
        memReady = ready;
        instructionOp = op;
        flagOp = fop;
        flags = flg;
        #1;
        got = {irLoad, pcEn, pcSel, regWrite, wbSel, flagWrite, memReq, memWrite, addrSel, state};
        check(tag, {18'b0, got}, {18'b0, exp});
        check({tag, " count"}, {16'b0, instrCount}, 32'(model_count));
        if (rst) model_count = 0;
        else if (exp.pc_en) model_count = (model_count + 1) % 65536;
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [3:0] fop, input logic [4:0] flg,
                             input int fetch_waits, input int mem_waits);
        kind_e k;
        obs_t  e;
        string nm;
        logic  taken;
        k = classify(op);
        taken = cond_true(fop, flg);
        nm = $sformatf("op%02h fop%h flg%02h", op, fop, flg);
        for (int i = 0; i < fetch_waits; i++) cycle({nm, " fetch-wait"}, 1'b0, 1'b0, op, fop, flg, fetch_wait());
        e = fetch_wait();
        e.ir_load = 1'b1;
        cycle({nm, " fetch"}, 1'b0, 1'b1, op, fop, flg, e);
        cycle({nm, " decode"}, 1'b0, 1'($urandom_range(0, 1)), op, fop, flg, blank(3'd1));
        e = blank(3'd2);
        case (k)
            K_ALU: begin
                e.reg_write = 1'b1;
                e.pc_en = 1'b1;
                e.flag_write = !(op == 8'h0D || op[7:4] == 4'hD || op[7:4] == 4'hF);
            end
            K_JAL: begin
                e.reg_write = 1'b1;
                e.wb_sel = 2'b10;
                e.pc_en = 1'b1;
                e.pc_sel = 2'b10;
            end
            K_JMP: begin
                e.pc_en = 1'b1;
                e.pc_sel = taken ? 2'b10 : 2'b00;
            end
            K_BR: begin
                e.pc_en = 1'b1;
                e.pc_sel = taken ? 2'b01 : 2'b00;
            end
            K_NOP: e.pc_en = 1'b1;
            default: ;
        endcase
        cycle({nm, " exec"}, 1'b0, 1'($urandom_range(0, 1)), op, fop, flg, e);
        if (k == K_LOAD || k == K_STOR) begin
            e = blank(3'd3);
            e.mem_req = 1'b1;
            e.addr_sel = 1'b1;
            e.mem_write = (k == K_STOR);
            for (int i = 0; i < mem_waits; i++) cycle({nm, " mem-wait"}, 1'b0, 1'b0, op, fop, flg, e);
            e.pc_en = (k == K_STOR);
            cycle({nm, " mem"}, 1'b0, 1'b1, op, fop, flg, e);
        end
        if (k == K_LOAD) begin
            e = blank(3'd4);
            e.reg_write = 1'b1;
            e.wb_sel = 2'b01;
            e.pc_en = 1'b1;
            cycle({nm, " wb"}, 1'b0, 1'($urandom_range(0, 1)), op, fop, flg, e);
        end
    endtask

    initial begin
        logic [7:0] pool [11];
        logic [7:0] op;
        obs_t       e;
        pool = '{8'h05, 8'h0D, 8'h13, 8'hD7, 8'hF2, 8'h83, 8'h40, 8'h44, 8'h48, 8'h4C, 8'hC9};

        repeat (2) @(posedge clk);
        cycle("reset", 1'b1, 1'b1, 8'h05, 4'h0, 5'h00, blank(3'd0));

        // Directed cases: ADD, LOAD with waits, Bcond taken/not taken/never, JAL.
        run_instr(8'h05, 4'h0, 5'h00, 0, 0);
        check("add retired", {16'b0, instrCount}, 32'd0);
        cycle("after add", 1'b0, 1'b0, 8'h05, 4'h0, 5'h00, fetch_wait());
        check("add count", {16'b0, instrCount}, 32'd1);
        run_instr(8'h40, 4'h0, 5'h00, 1, 3);
        run_instr(8'hC0, 4'h0, 5'b10000, 0, 0);
        run_instr(8'hC0, 4'h0, 5'b00000, 0, 0);
        run_instr(8'hC0, 4'hF, 5'b11111, 0, 0);
        run_instr(8'h48, 4'hF, 5'h00, 0, 0);
        run_instr(8'h4C, 4'h6, 5'b00010, 2, 0);
        run_instr(8'h44, 4'h0, 5'h00, 0, 2);

        // Reset asserted while a store waits on memory.
        e = fetch_wait();
        e.ir_load = 1'b1;
        cycle("stor fetch", 1'b0, 1'b1, 8'h44, 4'h0, 5'h00, e);
        cycle("stor decode", 1'b0, 1'b0, 8'h44, 4'h0, 5'h00, blank(3'd1));
        cycle("stor exec", 1'b0, 1'b0, 8'h44, 4'h0, 5'h00, blank(3'd2));
        e = blank(3'd3);
        e.mem_req = 1'b1;
        e.addr_sel = 1'b1;
        e.mem_write = 1'b1;
        cycle("stor mem-wait", 1'b0, 1'b0, 8'h44, 4'h0, 5'h00, e);
        cycle("stor reset", 1'b1, 1'b1, 8'h44, 4'h0, 5'h00, blank(3'd3));
        cycle("post reset", 1'b0, 1'b0, 8'h44, 4'h0, 5'h00, fetch_wait());
        check("post reset count", {16'b0, instrCount}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            int idx;
            idx = $urandom_range(0, 11);
            op = (idx == 11) ? 8'($urandom_range(0, 255)) : pool[idx];
            run_instr(op, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Counter wrap: preload 16'hFFFF while idling in FETCH, retire one NOP.
        @(negedge clk);
        reset = 1'b0;
        memReady = 1'b0;
        force dut.instr_count_q = 16'hFFFF;
        #1;
        release dut.instr_count_q;
        model_count = 65535;
        run_instr(8'h4F, 4'h0, 5'h00, 0, 0);
        cycle("after wrap", 1'b0, 1'b0, 8'h4F, 4'h0, 5'h00, fetch_wait());
        check("wrap", {16'b0, instrCount}, 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port instructionOp, input, 8, decoded opcode from the instruction decoder.
REQ-004 SHALL have port flagOp, input, 4, condition code from the decoder (Jcond/Bcond), 4'b1111 for JAL.
REQ-005 SHALL have port flags, input, 5, {Z,C,F,N,L} from the PSR register.
REQ-006 SHALL have port memReady, input, 1, memory completes the current access this cycle.
REQ-007 SHALL have port irLoad, output, 1, instruction register load strobe.
REQ-008 SHALL have port pcEn, output, 1, PC update strobe.
REQ-009 SHALL have port pcSel, output, 2, PC source: 00 PC+1, 01 PC+sign-extended immediate, 10 regA.
REQ-010 SHALL have port regWrite, output, 1, register file write strobe for regAddB.
REQ-011 SHALL have port wbSel, output, 2, writeback source: 00 ALU, 01 memory, 10 PC+1.
REQ-012 SHALL have port flagWrite, output, 1, PSR update strobe.
REQ-013 SHALL have ports memReq (1) and memWrite (1), outputs, memory request and write qualifier.
REQ-014 SHALL have port addrSel, output, 1, memory address source: 0 PC, 1 regA.
REQ-015 SHALL have port state, output, 3, current FSM state for debug.
REQ-016 SHALL have port instrCount, output, 16, retired-instruction counter.

Function
REQ-017 SHALL implement a Moore state register with these states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; strobes decode combinationally from the state register and inputs.
REQ-018 In FETCH, SHALL assert memReq=1 and addrSel=0; on memReady=1, SHALL assert irLoad=1 and go to DECODE; otherwise SHALL hold FETCH with irLoad=0.
REQ-019 SHALL spend exactly one cycle in DECODE with all strobes 0, then go to EXEC.
REQ-020 In EXEC, for the ALU class (instructionOp[7:4]=0000, or instructionOp[5]|instructionOp[4]) and the shift class (instructionOp[7:4]=1000), SHALL assert regWrite=1, wbSel=00 and pcEn=1 with pcSel=00, then go to FETCH.
REQ-021 For the ALU and shift classes, SHALL assert flagWrite=1, except for MOV (8'h0D), MOVI (upper nibble 1101) and LUI (upper nibble 1111).
REQ-022 For LOAD (8'h40) and STOR (8'h44), SHALL go from EXEC to MEM with no strobes asserted in EXEC.
REQ-023 In MEM, SHALL assert memReq=1 and addrSel=1, with memWrite=1 only for STOR; SHALL hold MEM until memReady=1.
- STOR: on memReady, pcEn=1, pcSel=00, next state FETCH.
- LOAD: on memReady, next state WB.
REQ-024 In WB, SHALL assert regWrite=1, wbSel=01 and pcEn=1 with pcSel=00, then go to FETCH.
REQ-025 For JAL (8'h48), EXEC SHALL assert regWrite=1, wbSel=10, pcEn=1 and pcSel=10, then go to FETCH.
REQ-026 For Jcond (upper nibble 0100, low nibble 1100), EXEC SHALL assert pcEn=1 with pcSel=10 if the condition is true, else pcSel=00, then go to FETCH.
REQ-027 For Bcond (upper nibble 1100), EXEC SHALL assert pcEn=1 with pcSel=01 if the condition is true, else pcSel=00, then go to FETCH.
REQ-028 SHALL evaluate flagOp against flags as follows:
- 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C.
- 4 HI: L; 5 LS: !L; 6 GT: N; 7 LE: !N.
- 8 FS: F; 9 FC: !F; A LO: !L&!Z; B HS: L|Z.
- C LT: !N&!Z; D GE: N|Z; E UC: 1; F: 0.
REQ-029 Any other opcode SHALL execute as a NOP: pcEn=1, pcSel=00, next state FETCH.
REQ-030 instrCount SHALL increment by 1 on every cycle where pcEn=1, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-031 State encodings 5-7 SHALL force the next state to FETCH with all strobes 0.
REQ-032 memReady SHALL be ignored in DECODE, EXEC and WB.

Reset
REQ-033 While reset=1, all strobes SHALL be 0 regardless of state.
REQ-034 On the clk edge with reset=1, state SHALL become FETCH and instrCount SHALL become 0, including when reset is asserted mid-MEM.
REQ-035 The first fetch SHALL begin on the first cycle after reset deasserts.

Verification
REQ-036 Bench SHALL cover: ADD (8'h05), memReady=1 in FETCH -> states FETCH, DECODE, EXEC; EXEC shows regWrite=1, flagWrite=1, pcEn=1; instrCount=1.
REQ-037 Bench SHALL cover: LOAD, memReady low for 3 MEM cycles -> MEM held 4 cycles, then WB with regWrite=1, wbSel=01; 5 states plus 3 waits total.
REQ-038 Bench SHALL cover: Bcond flagOp=0, Z=1 -> pcSel=01; repeat with Z=0 -> pcSel=00; flagOp=F -> always 00.
REQ-039 Bench SHALL cover: JAL -> single EXEC cycle with regWrite=1, wbSel=10, pcSel=10, flagWrite=0.
REQ-040 Bench SHALL cover: reset asserted during STOR MEM wait -> memReq=0 that cycle; next state FETCH; instrCount=0.
REQ-041 Bench SHALL cover: preload 65535 retirements, one more NOP -> instrCount=16'h0000.
